fft_peak_detector: RTL and testbench



---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_peak_detector_cplx_mag_sq.sv | 30 +++
 rtl/fft_peak_detector.sv | 156 +++++++++++++++
 tb/tb_fft_peak_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared widths, state encoding and complex-sample type for the
//            FFT peak detector.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  // log2 of the spectrum length; sample width tracks the point count
  localparam int FFT_N    = 3;
  localparam int W        = 2**FFT_N;
  localparam int MAG_W    = 2*W;
  localparam int ENERGY_W = 2*W + FFT_N;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

endpackage
`default_nettype wire

// File: rtl/fft_peak_detector_cplx_mag_sq.sv
`default_nettype none
// ============================================================================
// Module   : cplx_mag_sq
// Brief    : Combinational squared magnitude re*re + im*im of one complex
//            sample; signed operands, unsigned MAG_W-bit result.
// Revision : 1.0 - initial release
// ============================================================================
module cplx_mag_sq
  import fft_pkg::*;
(
  input  logic signed [W-1:0] re,
  input  logic signed [W-1:0] im,
  output logic [MAG_W-1:0]    mag
);

  logic signed [MAG_W-1:0] w_re_x;
  logic signed [MAG_W-1:0] w_im_x;
  logic signed [MAG_W-1:0] w_re_sq;
  logic signed [MAG_W-1:0] w_im_sq;

  // Sign-extend before multiplying so the product is formed at full width.
  // Each square is at most 2**(2W-2), so the sum of two fits MAG_W unsigned.
  assign w_re_x  = {{W{re[W-1]}}, re};
  assign w_im_x  = {{W{im[W-1]}}, im};
  assign w_re_sq = w_re_x * w_re_x;
  assign w_im_sq = w_im_x * w_im_x;
  assign mag     = $unsigned(w_re_sq) + $unsigned(w_im_sq);

endmodule
`default_nettype wire

// File: rtl/fft_peak_detector.sv
`default_nettype none
// ============================================================================
// Module   : fft_peak_detector
// Brief    : Captures an 8-bin complex spectrum in one cycle, then scans one
//            bin per cycle through a shared squarer to find the dominant bin,
//            its squared magnitude and the total frame energy.
// Revision : 1.0 - initial release
// ============================================================================
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int N = FFT_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_0_r,
  input  logic [W-1:0]        in_1_r,
  input  logic [W-1:0]        in_2_r,
  input  logic [W-1:0]        in_3_r,
  input  logic [W-1:0]        in_4_r,
  input  logic [W-1:0]        in_5_r,
  input  logic [W-1:0]        in_6_r,
  input  logic [W-1:0]        in_7_r,
  input  logic [W-1:0]        in_0_i,
  input  logic [W-1:0]        in_1_i,
  input  logic [W-1:0]        in_2_i,
  input  logic [W-1:0]        in_3_i,
  input  logic [W-1:0]        in_4_i,
  input  logic [W-1:0]        in_5_i,
  input  logic [W-1:0]        in_6_i,
  input  logic [W-1:0]        in_7_i,
  output logic                out_valid,
  output logic [N-1:0]        peak_idx,
  output logic [MAG_W-1:0]    peak_mag,
  output logic [ENERGY_W-1:0] energy,
  output logic                busy
);

  localparam int           BINS     = 2**N;
  localparam logic [N-1:0] LAST_IDX = N'(BINS-1);

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  cplx_t               w_in    [BINS];
  cplx_t               r_frame [BINS];
  cplx_t               w_sel;
  logic [N-1:0]        r_idx;
  logic [N-1:0]        r_max_idx;
  logic [MAG_W-1:0]    r_max;
  logic [MAG_W-1:0]    w_mag;
  logic [ENERGY_W-1:0] r_acc;
  logic [ENERGY_W-1:0] w_acc_next;
  logic                w_capture;
  logic                w_gt;
  logic                w_last;

  assign w_in[0] = {in_0_r, in_0_i};
  assign w_in[1] = {in_1_r, in_1_i};
  assign w_in[2] = {in_2_r, in_2_i};
  assign w_in[3] = {in_3_r, in_3_i};
  assign w_in[4] = {in_4_r, in_4_i};
  assign w_in[5] = {in_5_r, in_5_i};
  assign w_in[6] = {in_6_r, in_6_i};
  assign w_in[7] = {in_7_r, in_7_i};

  assign w_capture  = (r_state == IDLE) && in_valid;
  assign w_sel      = r_frame[r_idx];
  assign w_gt       = w_mag > r_max;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_acc_next = r_acc + ENERGY_W'(w_mag);

  // Single shared squarer, steered by the scan index
  cplx_mag_sq u_mag_sq (
    .re  (w_sel.re),
    .im  (w_sel.im),
    .mag (w_mag)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: the terminal bin is detected explicitly, never by wrap
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SCAN;
      SCAN:    if (w_last)   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      SCAN:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Frame capture; later input changes cannot disturb a frame being scanned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BINS; b++) r_frame[b] <= '0;
    end else if (w_capture) begin
      for (int b = 0; b < BINS; b++) r_frame[b] <= w_in[b];
    end
  end

  // Scan datapath: running max (strict compare keeps lowest index on ties)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_max     <= '0;
      r_max_idx <= '0;
      r_acc     <= '0;
    end else if (w_capture) begin
      r_idx     <= '0;
      r_max     <= '0;
      r_max_idx <= '0;
      r_acc     <= '0;
    end else if (r_state == SCAN) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
      r_acc <= w_acc_next;
      if (w_gt) begin
        r_max     <= w_mag;
        r_max_idx <= r_idx;
      end
    end
  end

  // Result registers: updated only on the last bin, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_idx <= '0;
      peak_mag <= '0;
      energy   <= '0;
    end else if ((r_state == SCAN) && w_last) begin
      peak_idx <= w_gt ? r_idx : r_max_idx;
      peak_mag <= w_gt ? w_mag : r_max;
      energy   <= w_acc_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_peak_detector
// Brief    : Scoreboard bench for fft_peak_detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_peak_detector;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] fr_r [8];
  logic signed [7:0] fr_i [8];
  logic              out_valid;
  logic [2:0]        peak_idx;
  logic [15:0]       peak_mag;
  logic [18:0]       energy;
  logic              busy;

  typedef struct {
    int idx;
    int mag;
    int nrg;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   hold_idx = 0;
  int   hold_mag = 0;
  int   hold_nrg = 0;

  fft_peak_detector dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_0_r(fr_r[0]), .in_1_r(fr_r[1]), .in_2_r(fr_r[2]), .in_3_r(fr_r[3]),
    .in_4_r(fr_r[4]), .in_5_r(fr_r[5]), .in_6_r(fr_r[6]), .in_7_r(fr_r[7]),
    .in_0_i(fr_i[0]), .in_1_i(fr_i[1]), .in_2_i(fr_i[2]), .in_3_i(fr_i[3]),
    .in_4_i(fr_i[4]), .in_5_i(fr_i[5]), .in_6_i(fr_i[6]), .in_7_i(fr_i[7]),
    .out_valid(out_valid), .peak_idx(peak_idx), .peak_mag(peak_mag),
    .energy(energy), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference result for the frame currently on the inputs
  function automatic exp_t model(input int due);
    exp_t e;
    int   m;
    e.idx = 0; e.mag = 0; e.nrg = 0; e.cyc = due;
    for (int b = 0; b < 8; b++) begin
      m = int'(fr_r[b]) * int'(fr_r[b]) + int'(fr_i[b]) * int'(fr_i[b]);
      e.nrg += m;
      if (m > e.mag) begin
        e.mag = m;
        e.idx = b;
      end
    end
    return e;
  endfunction

  task automatic clr();
    for (int b = 0; b < 8; b++) begin
      fr_r[b] = '0;
      fr_i[b] = '0;
    end
  endtask

  // Present the frame for one cycle once the block is idle
  task automatic send();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    sb.push_back(model(cyc + 9));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  // Output monitor: pop expected result on each out_valid pulse, and check
  // that results hold steady while scanning
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("peak_idx", peak_idx, e.idx);
        chk("peak_mag", peak_mag, e.mag);
        chk("energy", energy, e.nrg);
        hold_idx = e.idx;
        hold_mag = e.mag;
        hold_nrg = e.nrg;
      end
    end
    if (rst_n && busy) begin
      chk("scan_in_ready", in_ready, 0);
      chk("hold_idx", peak_idx, hold_idx);
      chk("hold_mag", peak_mag, hold_mag);
      chk("hold_energy", energy, hold_nrg);
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_peak_idx", peak_idx, 0);
    chk("rst_peak_mag", peak_mag, 0);
    chk("rst_energy", energy, 0);
    rst_n = 1'b1;

    // Directed frames
    clr(); send();
    clr(); fr_r[3] = 8'sh10; send();
    clr(); fr_r[2] = 8'sh7e; fr_r[6] = 8'sh7e; send();
    clr(); fr_r[7] = -8'sd128; fr_i[7] = -8'sd128; fr_r[0] = 8'sd1; send();
    for (int b = 0; b < 8; b++) begin
      fr_r[b] = -8'sd128;
      fr_i[b] = -8'sd128;
    end
    send();
    drain();

    // Random frames
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 8; b++) begin
        fr_r[b] = 8'($urandom);
        fr_i[b] = 8'($urandom);
      end
      send();
    end
    drain();

    // in_valid held high with inputs changing during the scan
    @(negedge clk);
    clr(); fr_r[5] = 8'sd90; fr_i[1] = -8'sd40;
    in_valid = 1'b1;
    sb.push_back(model(cyc + 9));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("held_busy", busy, 1);
      for (int b = 0; b < 8; b++) begin
        fr_r[b] = 8'($urandom);
        fr_i[b] = 8'($urandom);
      end
    end
    @(negedge clk);
    chk("done_in_ready", in_ready, 0);
    chk("done_busy", busy, 0);
    clr(); fr_i[6] = 8'sd33; fr_r[6] = 8'sd20;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    sb.push_back(model(cyc + 9));
    @(negedge clk);
    in_valid = 1'b0;
    chk("second_capture_busy", busy, 1);
    drain();

    // Asynchronous reset while the scan is at idx 4
    @(negedge clk);
    clr(); fr_r[4] = 8'sd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    hold_idx = 0; hold_mag = 0; hold_nrg = 0;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_peak_idx", peak_idx, 0);
    chk("arst_peak_mag", peak_mag, 0);
    chk("arst_energy", energy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst_idle", in_ready, 1);
    clr(); fr_r[1] = -8'sd7; fr_i[1] = 8'sd24; fr_r[0] = 8'sd3; send();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
